// File: rtl/pc_unit.sv
// Program counter for the NES CPU core. It handles variable step, signed relative
// branches with page-cross detection, absolute jumps and stall. A two-cycle vector
// sequencer services RESET, NMI and IRQ over a byte read handshake.
//
// Ports:
//   clk_i, rst_i          clock; synchronous active-high reset
//   stall_i               holds the PC; jump, branch and step are ignored
//   step_i                sequential increment (instruction length)
//   branch_taken_i/off_i  relative branch request and signed 8-bit offset
//   jump_i/target_i       absolute jump request and destination
//   nmi_i, irq_i          NMI (rising edge) and IRQ (level) requests
//   vec_rd_o/addr_o       vector byte read request and its address
//   vec_data_i/valid_i    returned vector byte; valid completes the read
//   pc_o, pc_valid_o      current PC; valid only in RUN
//   page_cross_o          last taken branch crossed a 256-byte page
//   busy_o                vector fetch in progress
//
// Optional macro PC_BREAKPOINT_EN adds bp_en_i, bp_addr_i and bp_hit_o. bp_hit_o is
// a registered one-cycle pulse that fires when pc_o reaches bp_addr_i in RUN.
//
// Latency: every PC update is visible one cycle after its inputs are sampled.
// A vector fetch takes at least two cycles from VEC_LO entry to RUN.
// Backpressure: vec_rd_o holds until vec_valid_i, and wait states are unbounded.
// stall_i freezes the PC in RUN.
module pc_unit #(
    parameter int          ADDR_W    = 16,
    parameter int          STEP_W    = 2,
    parameter logic [15:0] RESET_VEC = 16'hFFFC,
    parameter logic [15:0] NMI_VEC   = 16'hFFFA,
    parameter logic [15:0] IRQ_VEC   = 16'hFFFE
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic [STEP_W-1:0] step_i,
    input  logic              branch_taken_i,
    input  logic [7:0]        branch_off_i,
    input  logic              jump_i,
    input  logic [ADDR_W-1:0] jump_target_i,
    input  logic              nmi_i,
    input  logic              irq_i,
    output logic              vec_rd_o,
    output logic [15:0]       vec_addr_o,
    input  logic [7:0]        vec_data_i,
    input  logic              vec_valid_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic              pc_valid_o,
    output logic              page_cross_o,
    output logic              busy_o
`ifdef PC_BREAKPOINT_EN
    ,
    input  logic              bp_en_i,
    input  logic [ADDR_W-1:0] bp_addr_i,
    output logic              bp_hit_o
`endif
);

    localparam logic [1:0] ST_VEC_LO = 2'd0;
    localparam logic [1:0] ST_VEC_HI = 2'd1;
    localparam logic [1:0] ST_RUN    = 2'd2;

    logic [1:0]        state_q,      state_d;
    logic [15:0]       vec_base_q,   vec_base_d;
    logic [7:0]        vec_lo_q,     vec_lo_d;
    logic              vec_rd_q,     vec_rd_d;
    logic [15:0]       vec_addr_q,   vec_addr_d;
    logic [ADDR_W-1:0] pc_q,         pc_d;
    logic              pc_valid_q,   pc_valid_d;
    logic              page_cross_q, page_cross_d;
    logic              nmi_q,        nmi_d;
    logic              nmi_pend_q,   nmi_pend_d;

    // Datapath helpers. All of these wrap modulo 2^ADDR_W by width.
    logic [ADDR_W-1:0] seq_pc;
    logic [ADDR_W-1:0] off_ext;
    logic [ADDR_W-1:0] br_pc;
    logic              br_cross;
    logic [15:0]       vec_word;
    logic [ADDR_W-1:0] vec_pc;
    logic              nmi_edge;

    assign seq_pc   = pc_q + {{(ADDR_W-STEP_W){1'b0}}, step_i};
    assign off_ext  = {{(ADDR_W-8){branch_off_i[7]}}, branch_off_i};
    assign br_pc    = seq_pc + off_ext;
    // The page is judged against the fall-through address, not the branch opcode.
    assign br_cross = (br_pc[ADDR_W-1:8] != seq_pc[ADDR_W-1:8]);
    assign vec_word = {vec_data_i, vec_lo_q};
    assign vec_pc   = vec_word[ADDR_W-1:0];
    // nmi_q is the registered copy of nmi_i. The pending flag is set on the edge
    // where that copy goes from 0 to 1.
    assign nmi_edge = nmi_i & ~nmi_q;

    always_comb begin
        state_d      = state_q;
        vec_base_d   = vec_base_q;
        vec_lo_d     = vec_lo_q;
        vec_rd_d     = vec_rd_q;
        vec_addr_d   = vec_addr_q;
        pc_d         = pc_q;
        pc_valid_d   = pc_valid_q;
        page_cross_d = page_cross_q;
        nmi_d        = nmi_i;
        nmi_pend_d   = nmi_pend_q | nmi_edge;

        case (state_q)
            ST_VEC_LO: begin
                if (!vec_rd_q) begin
                    // This state is reached only after reset. Issue the request
                    // here so the request does not overlap the reset cycle.
                    vec_rd_d   = 1'b1;
                    vec_addr_d = vec_base_q;
                end else if (vec_valid_i) begin
                    vec_lo_d   = vec_data_i;
                    vec_addr_d = vec_base_q + 16'd1;
                    state_d    = ST_VEC_HI;
                end
            end

            ST_VEC_HI: begin
                if (vec_rd_q && vec_valid_i) begin
                    pc_d       = vec_pc;
                    pc_valid_d = 1'b1;
                    vec_rd_d   = 1'b0;
                    state_d    = ST_RUN;
                end
            end

            ST_RUN: begin
                if (!stall_i) begin
                    if (nmi_pend_q) begin
                        // A new edge seen in this same cycle stays pending.
                        nmi_pend_d = nmi_edge;
                        vec_base_d = NMI_VEC;
                        vec_addr_d = NMI_VEC;
                        vec_rd_d   = 1'b1;
                        pc_valid_d = 1'b0;
                        state_d    = ST_VEC_LO;
                    end else if (irq_i) begin
                        vec_base_d = IRQ_VEC;
                        vec_addr_d = IRQ_VEC;
                        vec_rd_d   = 1'b1;
                        pc_valid_d = 1'b0;
                        state_d    = ST_VEC_LO;
                    end else if (jump_i) begin
                        pc_d         = jump_target_i;
                        page_cross_d = 1'b0;
                    end else if (branch_taken_i) begin
                        pc_d         = br_pc;
                        page_cross_d = br_cross;
                    end else begin
                        pc_d = seq_pc;
                    end
                end
            end

            default: begin
                // Recover from an illegal encoding by restarting the reset fetch.
                state_d    = ST_VEC_LO;
                vec_base_d = RESET_VEC;
                vec_rd_d   = 1'b0;
                pc_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_VEC_LO;
            vec_base_q   <= RESET_VEC;
            vec_lo_q     <= 8'h00;
            vec_rd_q     <= 1'b0;
            vec_addr_q   <= RESET_VEC;
            pc_q         <= '0;
            pc_valid_q   <= 1'b0;
            page_cross_q <= 1'b0;
            nmi_q        <= 1'b0;
            nmi_pend_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            vec_base_q   <= vec_base_d;
            vec_lo_q     <= vec_lo_d;
            vec_rd_q     <= vec_rd_d;
            vec_addr_q   <= vec_addr_d;
            pc_q         <= pc_d;
            pc_valid_q   <= pc_valid_d;
            page_cross_q <= page_cross_d;
            nmi_q        <= nmi_d;
            nmi_pend_q   <= nmi_pend_d;
        end
    end

    assign vec_rd_o     = vec_rd_q;
    assign vec_addr_o   = vec_addr_q;
    assign pc_o         = pc_q;
    assign pc_valid_o   = pc_valid_q;
    assign page_cross_o = page_cross_q;
    assign busy_o       = (state_q != ST_RUN);

`ifdef PC_BREAKPOINT_EN
    logic bp_hit_q,  bp_hit_d;
    logic bp_seen_q, bp_seen_d;
    logic bp_match;

    assign bp_match = (state_q == ST_RUN) && bp_en_i && (pc_q == bp_addr_i);

    // bp_seen_q blocks a re-fire while the PC sits on the breakpoint. It is
    // cleared as soon as the PC moves.
    always_comb begin
        bp_hit_d  = bp_match && !bp_seen_q;
        bp_seen_d = (pc_d != pc_q) ? 1'b0 : (bp_seen_q | bp_match);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bp_hit_q  <= 1'b0;
            bp_seen_q <= 1'b0;
        end else begin
            bp_hit_q  <= bp_hit_d;
            bp_seen_q <= bp_seen_d;
        end
    end

    assign bp_hit_o = bp_hit_q;
`endif

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        stall_i;
    logic [1:0]  step_i;
    logic        branch_taken_i;
    logic [7:0]  branch_off_i;
    logic        jump_i;
    logic [15:0] jump_target_i;
    logic        nmi_i;
    logic        irq_i;
    logic        vec_rd_o;
    logic [15:0] vec_addr_o;
    logic [7:0]  vec_data_i;
    logic        vec_valid_i;
    logic [15:0] pc_o;
    logic        pc_valid_o;
    logic        page_cross_o;
    logic        busy_o;
`ifdef PC_BREAKPOINT_EN
    logic        bp_en_i;
    logic [15:0] bp_addr_i;
    logic        bp_hit_o;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [15:0] pc;
        logic        x;
    } exp_t;
    exp_t sb_q[$];

    logic [15:0] model_pc;
    logic        model_x;

    pc_unit dut (
        .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .step_i(step_i),
        .branch_taken_i(branch_taken_i), .branch_off_i(branch_off_i),
        .jump_i(jump_i), .jump_target_i(jump_target_i),
        .nmi_i(nmi_i), .irq_i(irq_i),
        .vec_rd_o(vec_rd_o), .vec_addr_o(vec_addr_o),
        .vec_data_i(vec_data_i), .vec_valid_i(vec_valid_i),
        .pc_o(pc_o), .pc_valid_o(pc_valid_o),
        .page_cross_o(page_cross_o), .busy_o(busy_o)
`ifdef PC_BREAKPOINT_EN
        , .bp_en_i(bp_en_i), .bp_addr_i(bp_addr_i), .bp_hit_o(bp_hit_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        stall_i = 0; step_i = 0; branch_taken_i = 0; branch_off_i = 0;
        jump_i = 0; jump_target_i = 0; nmi_i = 0; irq_i = 0;
        vec_data_i = 0; vec_valid_i = 0;
    endtask

    // Drive one RUN-mode cycle. The expected result is pushed when the cycle is
    // driven, then popped and compared once the edge has passed.
    task automatic run_cycle(input logic st, input logic [1:0] stp, input logic br,
                             input logic [7:0] off, input logic jmp, input logic [15:0] tgt);
        logic [15:0] seq;
        logic [15:0] nxt;
        int          off_s;
        exp_t        e;
        stall_i = st; step_i = stp; branch_taken_i = br; branch_off_i = off;
        jump_i = jmp; jump_target_i = tgt;
        if (!st) begin
            if (jmp) begin
                model_pc = tgt;
                model_x  = 1'b0;
            end else if (br) begin
                off_s    = off[7] ? int'(off) - 256 : int'(off);
                seq      = 16'((int'(model_pc) + int'(stp)) % 65536);
                nxt      = 16'((int'(seq) + off_s + 65536) % 65536);
                model_x  = (nxt[15:8] != seq[15:8]);
                model_pc = nxt;
            end else begin
                model_pc = 16'((int'(model_pc) + int'(stp)) % 65536);
            end
        end
        e.pc = model_pc;
        e.x  = model_x;
        sb_q.push_back(e);
        tick();
        n_checks++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_empty: no expectation queued for pc %h", pc_o);
        end else begin
            e = sb_q.pop_front();
            if ({pc_o, page_cross_o, pc_valid_o} !== {e.pc, e.x, 1'b1}) begin
                n_fail++;
                $display("FAIL run_cycle: got pc=%h x=%b v=%b want pc=%h x=%b v=1",
                         pc_o, page_cross_o, pc_valid_o, e.pc, e.x);
            end
        end
        idle_inputs();
    endtask

    // Complete a vector fetch that is already in VEC_LO with the request raised.
    task automatic do_fetch(input logic [15:0] base, input logic [7:0] lo,
                            input logic [7:0] hi, input int waits);
        n_checks++;
        if ({vec_rd_o, vec_addr_o} !== {1'b1, base}) begin
            n_fail++;
            $display("FAIL fetch_lo_req: got rd=%b addr=%h want rd=1 addr=%h", vec_rd_o, vec_addr_o, base);
        end
        for (int i = 0; i < waits; i++) begin
            tick();
            n_checks++;
            if ({vec_rd_o, vec_addr_o, busy_o} !== {1'b1, base, 1'b1}) begin
                n_fail++;
                $display("FAIL fetch_wait: got rd=%b addr=%h busy=%b want rd=1 addr=%h busy=1",
                         vec_rd_o, vec_addr_o, busy_o, base);
            end
        end
        vec_valid_i = 1; vec_data_i = lo;
        tick();
        n_checks++;
        if ({vec_rd_o, vec_addr_o, pc_valid_o} !== {1'b1, base + 16'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL fetch_hi_req: got rd=%b addr=%h v=%b want rd=1 addr=%h v=0",
                     vec_rd_o, vec_addr_o, pc_valid_o, base + 16'd1);
        end
        vec_data_i = hi;
        tick();
        vec_valid_i = 0;
        n_checks++;
        if ({pc_o, pc_valid_o, busy_o, vec_rd_o} !== {hi, lo, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL fetch_done: got pc=%h v=%b busy=%b rd=%b want pc=%h v=1 busy=0 rd=0",
                     pc_o, pc_valid_o, busy_o, vec_rd_o, {hi, lo});
        end
        model_pc = {hi, lo};
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_i = 1;
        tick();
        tick();
        n_checks++;
        if ({pc_o, pc_valid_o, page_cross_o, busy_o, vec_rd_o} !== {16'h0000, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: got pc=%h v=%b x=%b busy=%b rd=%b want 0000 0 0 1 0",
                     pc_o, pc_valid_o, page_cross_o, busy_o, vec_rd_o);
        end
        // A stray valid while no read is outstanding must be ignored.
        rst_i = 0; vec_valid_i = 1; vec_data_i = 8'h55;
        tick();
        vec_valid_i = 0;
        n_checks++;
        if ({vec_rd_o, vec_addr_o, busy_o} !== {1'b1, 16'hFFFC, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_first_req: got rd=%b addr=%h busy=%b want rd=1 addr=fffc busy=1",
                     vec_rd_o, vec_addr_o, busy_o);
        end
        do_fetch(16'hFFFC, 8'h34, 8'h80, 1);
        model_x = 1'b0;
    endtask

    task automatic test_steps();
        run_cycle(0, 2'd1, 0, 8'h00, 0, 16'h0000);
        run_cycle(0, 2'd2, 0, 8'h00, 0, 16'h0000);
        run_cycle(0, 2'd3, 0, 8'h00, 0, 16'h0000);
        run_cycle(0, 2'd0, 0, 8'h00, 0, 16'h0000);
        n_checks++;
        if (pc_o !== 16'h803A) begin
            n_fail++;
            $display("FAIL steps_const: got %h want 803a", pc_o);
        end
        run_cycle(0, 2'd1, 0, 8'h00, 1, 16'hFFFF);
        run_cycle(0, 2'd1, 0, 8'h00, 0, 16'h0000);
        n_checks++;
        if (pc_o !== 16'h0000) begin
            n_fail++;
            $display("FAIL wrap_const: got %h want 0000", pc_o);
        end
    endtask

    task automatic test_branches();
        run_cycle(0, 2'd0, 0, 8'h00, 1, 16'h80F0);
        run_cycle(0, 2'd2, 1, 8'h20, 0, 16'h0000);
        n_checks++;
        if ({pc_o, page_cross_o} !== {16'h8112, 1'b1}) begin
            n_fail++;
            $display("FAIL branch_fwd: got pc=%h x=%b want 8112 1", pc_o, page_cross_o);
        end
        run_cycle(0, 2'd0, 0, 8'h00, 1, 16'h8010);
        run_cycle(0, 2'd2, 1, 8'hF0, 0, 16'h0000);
        n_checks++;
        if ({pc_o, page_cross_o} !== {16'h8002, 1'b0}) begin
            n_fail++;
            $display("FAIL branch_back: got pc=%h x=%b want 8002 0", pc_o, page_cross_o);
        end
        // Backward branch wrapping below zero.
        run_cycle(0, 2'd0, 0, 8'h00, 1, 16'h0005);
        run_cycle(0, 2'd0, 1, 8'h80, 0, 16'h0000);
        n_checks++;
        if ({pc_o, page_cross_o} !== {16'hFF85, 1'b1}) begin
            n_fail++;
            $display("FAIL branch_wrap: got pc=%h x=%b want ff85 1", pc_o, page_cross_o);
        end
    endtask

    task automatic test_priority();
        run_cycle(0, 2'd1, 1, 8'h10, 1, 16'hC000);
        n_checks++;
        if ({pc_o, page_cross_o} !== {16'hC000, 1'b0}) begin
            n_fail++;
            $display("FAIL jump_over_branch: got pc=%h x=%b want c000 0", pc_o, page_cross_o);
        end
        run_cycle(0, 2'd0, 1, 8'h80, 0, 16'h0000);
        run_cycle(1, 2'd1, 1, 8'h10, 1, 16'h1234);
        n_checks++;
        if ({pc_o, page_cross_o} !== {16'hBF80, 1'b1}) begin
            n_fail++;
            $display("FAIL stall_hold: got pc=%h x=%b want bf80 1", pc_o, page_cross_o);
        end
        run_cycle(0, 2'd3, 0, 8'h00, 0, 16'h0000);
    endtask

    task automatic test_interrupts();
        logic [15:0] held;
        held = pc_o;
        stall_i = 1; irq_i = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if ({vec_rd_o, busy_o, pc_valid_o, pc_o} !== {1'b0, 1'b0, 1'b1, held}) begin
                n_fail++;
                $display("FAIL irq_stalled: got rd=%b busy=%b v=%b pc=%h want 0 0 1 %h",
                         vec_rd_o, busy_o, pc_valid_o, pc_o, held);
            end
        end
        stall_i = 0;
        tick();
        irq_i = 0;
        n_checks++;
        if ({vec_rd_o, vec_addr_o, pc_valid_o, pc_o} !== {1'b1, 16'hFFFE, 1'b0, held}) begin
            n_fail++;
            $display("FAIL irq_enter: got rd=%b addr=%h v=%b pc=%h want 1 fffe 0 %h",
                     vec_rd_o, vec_addr_o, pc_valid_o, pc_o, held);
        end
        // An NMI pulse during the IRQ fetch is serviced right after RUN is entered.
        nmi_i = 1; vec_valid_i = 1; vec_data_i = 8'h00;
        tick();
        nmi_i = 0; vec_data_i = 8'h90;
        tick();
        vec_valid_i = 0;
        n_checks++;
        if ({pc_o, pc_valid_o, busy_o} !== {16'h9000, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL irq_done: got pc=%h v=%b busy=%b want 9000 1 0", pc_o, pc_valid_o, busy_o);
        end
        tick();
        n_checks++;
        if ({vec_rd_o, vec_addr_o, pc_valid_o, pc_o} !== {1'b1, 16'hFFFA, 1'b0, 16'h9000}) begin
            n_fail++;
            $display("FAIL nmi_enter: got rd=%b addr=%h v=%b pc=%h want 1 fffa 0 9000",
                     vec_rd_o, vec_addr_o, pc_valid_o, pc_o);
        end
        do_fetch(16'hFFFA, 8'h00, 8'hA0, 2);
    endtask

    task automatic test_reset_mid_fetch();
        irq_i = 1;
        tick();
        irq_i = 0; vec_valid_i = 1; vec_data_i = 8'h12;
        tick();
        vec_valid_i = 0;
        n_checks++;
        if ({vec_rd_o, vec_addr_o} !== {1'b1, 16'hFFFF}) begin
            n_fail++;
            $display("FAIL mid_hi_req: got rd=%b addr=%h want 1 ffff", vec_rd_o, vec_addr_o);
        end
        rst_i = 1;
        tick();
        rst_i = 0;
        n_checks++;
        if ({vec_rd_o, pc_valid_o, busy_o, pc_o} !== {1'b0, 1'b0, 1'b1, 16'h0000}) begin
            n_fail++;
            $display("FAIL mid_reset: got rd=%b v=%b busy=%b pc=%h want 0 0 1 0000",
                     vec_rd_o, pc_valid_o, busy_o, pc_o);
        end
        tick();
        do_fetch(16'hFFFC, 8'h34, 8'h80, 0);
        model_x = 1'b0;
    endtask

`ifdef PC_BREAKPOINT_EN
    task automatic test_breakpoint();
        int hits;
        hits = 0;
        bp_en_i = 1; bp_addr_i = 16'h8037;
        run_cycle(0, 2'd1, 0, 8'h00, 0, 16'h0000);
        hits += int'(bp_hit_o);
        run_cycle(0, 2'd2, 0, 8'h00, 0, 16'h0000);
        hits += int'(bp_hit_o);
        for (int i = 0; i < 4; i++) begin
            run_cycle(0, 2'd0, 0, 8'h00, 0, 16'h0000);
            hits += int'(bp_hit_o);
        end
        n_checks++;
        if (hits != 1) begin
            n_fail++;
            $display("FAIL bp_pulse: got %0d hit cycles want 1", hits);
        end
        bp_en_i = 0;
    endtask
`endif

    task automatic test_back_to_back();
        for (int i = 0; i < 40; i++) begin
            run_cycle(($urandom_range(0, 5) == 0), 2'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                      ($urandom_range(0, 7) == 0), 16'($urandom_range(0, 65535)));
        end
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover: got %0d entries want 0", sb_q.size());
        end
    endtask

    initial begin
        rst_i = 1;
        model_pc = 16'h0000;
        model_x  = 1'b0;
`ifdef PC_BREAKPOINT_EN
        bp_en_i = 0; bp_addr_i = 0;
`endif
        test_reset();
        test_steps();
        test_branches();
        test_priority();
        test_interrupts();
        test_reset_mid_fetch();
`ifdef PC_BREAKPOINT_EN
        test_breakpoint();
`endif
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
